// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle WIDTH-bit subtractor: Diff = A - B - Bin, one 4-bit nibble per clock,
// least-significant nibble first. Each nibble is resolved by a flattened
// borrow-lookahead cell. Operands and results use valid/ready handshakes.
module nibble_serial_subtractor #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Ovf,
    output logic             Zero
);

    localparam int unsigned NIB = WIDTH / 4;
    localparam int unsigned IW  = (NIB > 1) ? $clog2(NIB) : 1;

    if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_width_check
        $error("nibble_serial_subtractor: WIDTH must be a multiple of 4 and at least 4");
    end

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             bw_q, bw_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic [3:0]       a_nib, b_nib;
    logic [3:0]       g, p, bw;
    logic [3:0]       d_nib;
    logic             nib_bout;
    logic [IW+1:0]    sh;
    logic             last;

    assign sh   = {idx_q, 2'b00};
    assign last = (idx_q == IW'(NIB - 1));

    // Borrow-lookahead cell for the nibble selected by idx_q; no rippling between bits.
    always_comb begin
        a_nib = a_q[sh +: 4];
        b_nib = b_q[sh +: 4];
        g     = ~a_nib & b_nib;
        p     = ~(a_nib ^ b_nib);
        bw[0] = bw_q;
        bw[1] = g[0] | (p[0] & bw_q);
        bw[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bw_q);
        bw[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bw_q);
        nib_bout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                 | (p[3] & p[2] & p[1] & p[0] & bw_q);
        d_nib = a_nib ^ b_nib ^ bw;
    end

    // Next-state logic: accept in idle, one nibble per cycle in run, hold until retired.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_valid) state_d = StRun;
            StRun:   if (last) state_d = StDone;
            StDone:  if (result_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state: operand capture, nibble write-back and end-of-run flags.
    always_comb begin
        idx_d  = idx_q;
        a_d    = a_q;
        b_d    = b_q;
        bw_d   = bw_q;
        diff_d = diff_q;
        bout_d = bout_q;
        ovf_d  = ovf_q;
        zero_d = zero_q;
        if (state_q == StIdle && start_valid) begin
            a_d   = A;
            b_d   = B;
            bw_d  = Bin;
            idx_d = '0;
        end else if (state_q == StRun) begin
            diff_d[sh +: 4] = d_nib;
            bw_d            = nib_bout;
            idx_d           = last ? '0 : idx_q + IW'(1);
            if (last) begin
                // Flags see the full result including the nibble written this cycle.
                bout_d = nib_bout;
                ovf_d  = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ diff_d[WIDTH-1]);
                zero_d = (diff_d == '0);
            end
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            bw_q    <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            bw_q    <= bw_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign start_ready  = (state_q == StIdle);
    assign result_valid = (state_q == StDone);
    assign Diff         = diff_q;
    assign Bout         = bout_q;
    assign Ovf          = ovf_q;
    assign Zero         = zero_q;

endmodule
